fp_sqrt_sequencer: RTL and testbench

//  Issue/retire stage wrapped around the pipelined single-precision square-root core.

---
 rtl/fp_sqrt_sequencer.sv | 153 +++++++++++++++
 tb/tb_fp_sqrt_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_sqrt_sequencer.sv
// Issue/retire sequencer around a fixed-latency single-precision sqrt core.
// Classifies operands, bypasses IEEE specials, and retires results in order through a credit-bounded FIFO.
module fp_sqrt_sequencer #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned LAT        = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_data,
  output logic [XLEN-1:0] core_a,
  input  logic [XLEN-1:0] core_result,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [2:0]      out_flags,
  output logic            busy
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] OCC_MAX = (CW+1)'(FIFO_DEPTH);

  localparam logic [XLEN-1:0] QNAN    = XLEN'(32'h7FC0_0000);
  localparam logic [XLEN-1:0] POS_INF = XLEN'(32'h7F80_0000);

  localparam logic [2:0] FL_NV = 3'b100;
  localparam logic [2:0] FL_FZ = 3'b010;
  localparam logic [2:0] FL_SP = 3'b001;

  logic            w_accept;
  logic            w_s;
  logic [7:0]      w_e;
  logic [22:0]     w_m;
  logic            w_special;
  logic [2:0]      w_flags;
  logic [XLEN-1:0] w_spec_res;

  logic            r_tag_vld [LAT];
  logic            r_tag_sp  [LAT];
  logic [2:0]      r_tag_fl  [LAT];
  logic [XLEN-1:0] r_tag_res [LAT];

  logic [XLEN-1:0] r_mem_data  [FIFO_DEPTH];
  logic [2:0]      r_mem_flags [FIFO_DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   r_inflight;

  logic            w_retire;
  logic            w_pop;
  logic [XLEN-1:0] w_push_data;
  logic [2:0]      w_push_flags;
  logic [CW:0]     w_occ;

  // Credit covers both in-flight and queued work, so a retiring op always finds a slot.
  assign w_occ    = {1'b0, r_inflight} + {1'b0, r_count};
  assign in_ready = !rst && (w_occ < OCC_MAX);
  assign w_accept = in_valid && in_ready;
  assign core_a   = w_accept ? in_data : '0;

  assign w_s = in_data[31];
  assign w_e = in_data[30:23];
  assign w_m = in_data[22:0];

  // Operand classification; only positive normals go to the core.
  always_comb begin
    w_special  = 1'b1;
    w_flags    = FL_SP;
    w_spec_res = '0;
    if (w_e == 8'h00) begin
      w_spec_res[XLEN-1] = w_s;
      if (w_m != 23'h0) w_flags = FL_SP | FL_FZ;
    end else if ((w_e == 8'hFF) && (w_m != 23'h0)) begin
      w_spec_res = QNAN;
      if (!w_m[22]) w_flags = FL_NV | FL_SP;
    end else if (w_s) begin
      w_spec_res = QNAN;
      w_flags    = FL_NV | FL_SP;
    end else if (w_e == 8'hFF) begin
      w_spec_res = POS_INF;
    end else begin
      w_special = 1'b0;
      w_flags   = 3'b000;
    end
  end

  // Tag pipeline mirrors the core latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        r_tag_vld[i] <= 1'b0;
        r_tag_sp[i]  <= 1'b0;
        r_tag_fl[i]  <= 3'b000;
        r_tag_res[i] <= '0;
      end
    end else begin
      r_tag_vld[0] <= w_accept;
      r_tag_sp[0]  <= w_special;
      r_tag_fl[0]  <= w_flags;
      r_tag_res[0] <= w_spec_res;
      for (int i = 1; i < LAT; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_sp[i]  <= r_tag_sp[i-1];
        r_tag_fl[i]  <= r_tag_fl[i-1];
        r_tag_res[i] <= r_tag_res[i-1];
      end
    end
  end

  assign w_retire     = r_tag_vld[LAT-1];
  assign w_push_data  = r_tag_sp[LAT-1] ? r_tag_res[LAT-1] : core_result;
  assign w_push_flags = r_tag_fl[LAT-1];
  assign w_pop        = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (w_retire) begin
      r_mem_data[r_wptr]  <= w_push_data;
      r_mem_flags[r_wptr] <= w_push_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_inflight <= '0;
    end else begin
      if (w_retire) r_wptr <= r_wptr + PW'(1);
      if (w_pop)    r_rptr <= r_rptr + PW'(1);
      case ({w_retire, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      case ({w_accept, w_retire})
        2'b10:   r_inflight <= r_inflight + CW'(1);
        2'b01:   r_inflight <= r_inflight - CW'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  assign out_valid = (r_count != '0);
  assign out_data  = out_valid ? r_mem_data[r_rptr]  : '0;
  assign out_flags = out_valid ? r_mem_flags[r_rptr] : 3'b000;
  assign busy      = (r_inflight != '0) || (r_count != '0);

endmodule

// File: tb/tb_fp_sqrt_sequencer.sv
// Directed bench for fp_sqrt_sequencer: vector table for classification/latency plus
// multi-cycle sequences for backpressure, ordering and mid-flight reset.
module tb_fp_sqrt_sequencer;

  localparam int LAT   = 8;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [31:0] core_a;
  logic [31:0] core_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_flags;
  logic        busy;

  fp_sqrt_sequencer #(.XLEN(32), .LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .core_a(core_a), .core_result(core_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_flags(out_flags), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fixed-latency core model: small lookup of exact square roots.
  function automatic logic [31:0] sqrt_lut(input logic [31:0] a);
    case (a)
      32'h4080_0000: sqrt_lut = 32'h4000_0000;
      32'h4110_0000: sqrt_lut = 32'h4040_0000;
      32'h3F80_0000: sqrt_lut = 32'h3F80_0000;
      32'h4180_0000: sqrt_lut = 32'h4080_0000;
      default:       sqrt_lut = 32'hDEAD_BEEF;
    endcase
  endfunction

  logic [31:0] core_pipe [LAT];
  always @(posedge clk) begin
    core_pipe[0] <= core_a;
    for (int i = 1; i < LAT; i++) core_pipe[i] <= core_pipe[i-1];
  end
  assign core_result = sqrt_lut(core_pipe[LAT-1]);

  logic [34:0] rx_q[$];
  logic [34:0] exp_q[$];

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) rx_q.push_back({out_flags, out_data});
  end

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] din;
    logic [31:0] dout;
    logic [2:0]  flags;
  } vec_t;
  vec_t vecs[14];

  task automatic chk(input string name, input logic [34:0] act, input logic [34:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic [31:0] ed, input logic [2:0] ef);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && waited < 100) begin
      tick();
      waited++;
    end
    if (!in_ready) begin
      chk("send_in_ready", 35'(in_ready), 35'(1));
    end else begin
      tick();
      exp_q.push_back({ef, ed});
    end
    in_valid = 1'b0;
    in_data  = 32'h0;
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    while (!out_valid && k < 40) begin
      tick();
      k++;
    end
  endtask

  task automatic drain_and_compare(input string name);
    int waited;
    waited = 0;
    while (rx_q.size() < exp_q.size() && waited < 200) begin
      tick();
      waited++;
    end
    chk({name, "_count"}, 35'(rx_q.size()), 35'(exp_q.size()));
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
      chk({name, "_order"}, rx_q[i], exp_q[i]);
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int seen;

    vecs[0]  = '{32'h4080_0000, 32'h4000_0000, 3'b000};
    vecs[1]  = '{32'hBF80_0000, 32'h7FC0_0000, 3'b101};
    vecs[2]  = '{32'h0000_0000, 32'h0000_0000, 3'b001};
    vecs[3]  = '{32'h8000_0000, 32'h8000_0000, 3'b001};
    vecs[4]  = '{32'h0000_0001, 32'h0000_0000, 3'b011};
    vecs[5]  = '{32'h8000_0001, 32'h8000_0000, 3'b011};
    vecs[6]  = '{32'h7F80_0000, 32'h7F80_0000, 3'b001};
    vecs[7]  = '{32'hFF80_0000, 32'h7FC0_0000, 3'b101};
    vecs[8]  = '{32'h7F80_0001, 32'h7FC0_0000, 3'b101};
    vecs[9]  = '{32'h7FC0_0000, 32'h7FC0_0000, 3'b001};
    vecs[10] = '{32'hFFC0_0001, 32'h7FC0_0000, 3'b001};
    vecs[11] = '{32'h4110_0000, 32'h4040_0000, 3'b000};
    vecs[12] = '{32'h3F80_0000, 32'h3F80_0000, 3'b000};
    vecs[13] = '{32'h0080_0000, 32'hDEAD_BEEF, 3'b000};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    out_ready = 1'b1;
    #1;
    chk("rst_in_ready", 35'(in_ready), 35'(0));
    repeat (3) tick();
    chk("rst_out_valid", 35'(out_valid), 35'(0));
    chk("rst_busy",      35'(busy),      35'(0));
    chk("rst_out_data",  35'(out_data),  35'(0));
    chk("rst_out_flags", 35'(out_flags), 35'(0));
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 35'(in_ready), 35'(1));
    chk("idle_core_a",       35'(core_a),   35'(0));
    tick();

    // Single ops: latency, result and flags per vector.
    for (int v = 0; v < 14; v++) begin
      rx_q.delete();
      exp_q.delete();
      send(vecs[v].din, vecs[v].dout, vecs[v].flags);
      wait_valid(k);
      chk($sformatf("vec%0d_latency", v), 35'(k), 35'(LAT));
      chk($sformatf("vec%0d_data", v),    35'(out_data),  35'(vecs[v].dout));
      chk($sformatf("vec%0d_flags", v),   35'(out_flags), 35'(vecs[v].flags));
      tick();
      tick();
      chk($sformatf("vec%0d_idle", v), 35'(busy), 35'(0));
    end
    rx_q.delete();
    exp_q.delete();

    // Backpressure: credit exhausts after 4 accepts, head holds, nothing lost.
    out_ready = 1'b0;
    send(32'h4080_0000, 32'h4000_0000, 3'b000);
    send(32'h8000_0000, 32'h8000_0000, 3'b001);
    send(32'h4110_0000, 32'h4040_0000, 3'b000);
    send(32'h0000_0001, 32'h0000_0000, 3'b011);
    chk("bp_in_ready_low", 35'(in_ready), 35'(0));
    repeat (LAT + 2) tick();
    chk("bp_out_valid", 35'(out_valid), 35'(1));
    chk("bp_head_data", 35'(out_data),  35'(32'h4000_0000));
    chk("bp_in_ready_full", 35'(in_ready), 35'(0));
    repeat (3) tick();
    chk("bp_head_stable",  35'(out_data),  35'(32'h4000_0000));
    chk("bp_flags_stable", 35'(out_flags), 35'(0));
    chk("bp_busy", 35'(busy), 35'(1));
    out_ready = 1'b1;
    send(32'h7F80_0001, 32'h7FC0_0000, 3'b101);
    send(32'h3F80_0000, 32'h3F80_0000, 3'b000);
    drain_and_compare("bp");

    // Interleaved normal / NaN / zero stream at maximum acceptance rate.
    send(32'h4080_0000, 32'h4000_0000, 3'b000);
    send(32'h7F80_0001, 32'h7FC0_0000, 3'b101);
    send(32'h4110_0000, 32'h4040_0000, 3'b000);
    send(32'h7F80_0001, 32'h7FC0_0000, 3'b101);
    send(32'h8000_0000, 32'h8000_0000, 3'b001);
    send(32'h0000_0001, 32'h0000_0000, 3'b011);
    send(32'h4180_0000, 32'h4080_0000, 3'b000);
    send(32'hBF80_0000, 32'h7FC0_0000, 3'b101);
    drain_and_compare("ilv");
    repeat (2) tick();

    // Reset with ops in flight: everything dropped, stale core results ignored.
    send(32'h4080_0000, 32'h4000_0000, 3'b000);
    send(32'h4110_0000, 32'h4040_0000, 3'b000);
    send(32'h3F80_0000, 32'h3F80_0000, 3'b000);
    tick();
    chk("mid_busy", 35'(busy), 35'(1));
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 35'(in_ready), 35'(0));
    tick();
    chk("mid_rst_out_valid", 35'(out_valid), 35'(0));
    chk("mid_rst_busy",      35'(busy),      35'(0));
    rst = 1'b0;
    rx_q.delete();
    exp_q.delete();
    seen = 0;
    for (int c = 0; c < LAT + 4; c++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("mid_rst_no_output", 35'(seen),        35'(0));
    chk("mid_rst_rx_empty",  35'(rx_q.size()), 35'(0));
    chk("mid_rst_in_ready",  35'(in_ready),    35'(1));

    // Recovery after reset.
    send(32'h4080_0000, 32'h4000_0000, 3'b000);
    drain_and_compare("recover");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
